// File: rtl/plab4_net_router_input_terminal_ctrl_tdm_pkg.sv
// Shared encodings for the TDM terminal-input control: route codes, request bit
// positions and FSM states.
package plab4_net_router_input_terminal_ctrl_tdm_pkg;

   localparam int unsigned ROUTE_NBITS = 2;
   localparam logic [ROUTE_NBITS-1:0] ROUTE_PREV = 2'd0;
   localparam logic [ROUTE_NBITS-1:0] ROUTE_TERM = 2'd1;
   localparam logic [ROUTE_NBITS-1:0] ROUTE_NEXT = 2'd2;

   localparam int unsigned REQ_NBITS = 3;
   localparam int unsigned REQ_PREV  = 0;
   localparam int unsigned REQ_TERM  = 1;
   localparam int unsigned REQ_NEXT  = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

endpackage

// File: rtl/plab4_net_router_input_terminal_ctrl_tdm_if.sv
// Handshake bundle between the terminal input queue, output arbiters and the
// terminal-input control.
interface plab4_net_router_input_terminal_ctrl_tdm_if
   import plab4_net_router_input_terminal_ctrl_tdm_pkg::*;
#(
   parameter int unsigned p_dest_nbits = 3,
   parameter int unsigned p_dom_nbits  = 1,
   parameter int unsigned p_free_nbits = 2
);
   logic [p_dest_nbits-1:0] dest;
   logic [p_dom_nbits-1:0]  in_domain;
   logic                    in_val;
   logic                    in_rdy;
   logic [p_free_nbits-1:0] num_free_west;
   logic [p_free_nbits-1:0] num_free_east;
   logic [REQ_NBITS-1:0]    reqs;
   logic [REQ_NBITS-1:0]    grants;

   modport master (
      output dest, in_domain, in_val, num_free_west, num_free_east, grants,
      input  in_rdy, reqs
   );

   modport slave (
      input  dest, in_domain, in_val, num_free_west, num_free_east, grants,
      output in_rdy, reqs
   );
endinterface

// File: rtl/plab4_net_GreedyRouteCompute.sv
// Greedy ring routing: choose the shorter direction to dest; ties go prev.
module plab4_net_GreedyRouteCompute
   import plab4_net_router_input_terminal_ctrl_tdm_pkg::*;
#(
   parameter int unsigned p_router_id   = 0,
   parameter int unsigned p_num_routers = 8,
   parameter int unsigned c_dest_nbits  = $clog2(p_num_routers)
)(
   input  logic [c_dest_nbits-1:0] dest,
   output logic [ROUTE_NBITS-1:0]  route
);
   int unsigned d;
   int unsigned fwd_hops;
   int unsigned bwd_hops;

   always_comb begin
      d        = 32'(dest);
      fwd_hops = (d + p_num_routers - p_router_id) % p_num_routers;
      bwd_hops = (p_router_id + p_num_routers - d) % p_num_routers;
      route    = ROUTE_PREV;
      if (fwd_hops == 0)
         route = ROUTE_TERM;
      else if (fwd_hops < bwd_hops)
         route = ROUTE_NEXT;
   end
endmodule

// File: rtl/plab4_net_tdm_slot_timer.sv
// Slot timer rotating the active security domain; shared by all input controls
// of a router so every port switches domain on the same cycle.
module plab4_net_tdm_slot_timer #(
   parameter int unsigned p_num_domains  = 2,
   parameter int unsigned p_slot_cycles  = 8,
   parameter int unsigned p_guard_cycles = 2,
   parameter int unsigned c_dom_nbits    = $clog2(p_num_domains)
)(
   input  logic                   clk,
   input  logic                   reset_n,
   output logic [c_dom_nbits-1:0] cur_domain,
   output logic                   slot_guard
);
   localparam int unsigned c_cnt_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
   localparam logic [c_cnt_nbits-1:0] c_cnt_last    = c_cnt_nbits'(p_slot_cycles - 1);
   localparam logic [c_cnt_nbits-1:0] c_guard_start = c_cnt_nbits'(p_slot_cycles - p_guard_cycles);
   localparam logic [c_dom_nbits-1:0] c_dom_last    = c_dom_nbits'(p_num_domains - 1);

   logic [c_cnt_nbits-1:0] slot_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_cnt   <= '0;
         cur_domain <= '0;
      end else if (slot_cnt == c_cnt_last) begin
         slot_cnt   <= '0;
         cur_domain <= (cur_domain == c_dom_last) ? '0 : cur_domain + c_dom_nbits'(1);
      end else begin
         slot_cnt   <= slot_cnt + c_cnt_nbits'(1);
      end
   end

   // Guard window: last p_guard_cycles of every slot
   assign slot_guard = (slot_cnt >= c_guard_start);
endmodule

// File: rtl/plab4_net_router_input_terminal_ctrl_tdm.sv
// Terminal-input control with TDM timing-channel protection: only the active
// domain may request, and requests are withdrawn during each slot's guard window.
module plab4_net_router_input_terminal_ctrl_tdm
   import plab4_net_router_input_terminal_ctrl_tdm_pkg::*;
#(
   parameter int unsigned p_router_id      = 0,
   parameter int unsigned p_num_routers    = 8,
   parameter int unsigned p_num_free_nbits = 2,
   parameter int unsigned p_num_domains    = 2,
   parameter int unsigned p_slot_cycles    = 8,
   parameter int unsigned p_guard_cycles   = 2,
   parameter int unsigned c_dest_nbits     = $clog2(p_num_routers),
   parameter int unsigned c_dom_nbits      = $clog2(p_num_domains)
)(
   input  logic                   clk,
   input  logic                   reset_n,
   plab4_net_router_input_terminal_ctrl_tdm_if.slave term,
   output logic [c_dom_nbits-1:0] cur_domain,
   output logic                   slot_guard
);
   localparam logic [p_num_free_nbits-1:0] c_free_min = p_num_free_nbits'(1);

   state_t                 state;
   state_t                 state_nxt;
   logic [ROUTE_NBITS-1:0] route_c;
   logic [ROUTE_NBITS-1:0] route_q;
   logic [REQ_NBITS-1:0]   reqs_c;
   logic                   in_rdy_c;
   logic                   eligible_c;

   plab4_net_tdm_slot_timer #(
      .p_num_domains  (p_num_domains),
      .p_slot_cycles  (p_slot_cycles),
      .p_guard_cycles (p_guard_cycles),
      .c_dom_nbits    (c_dom_nbits)
   ) u_slot_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .cur_domain (cur_domain),
      .slot_guard (slot_guard)
   );

   plab4_net_GreedyRouteCompute #(
      .p_router_id   (p_router_id),
      .p_num_routers (p_num_routers),
      .c_dest_nbits  (c_dest_nbits)
   ) u_route (
      .dest  (term.dest),
      .route (route_c)
   );

   assign eligible_c = term.in_val && (term.in_domain == cur_domain) && !slot_guard;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         route_q <= ROUTE_TERM;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && eligible_c)
            route_q <= route_c;
      end
   end

   // Requests come only from the latched route; bubble rule keeps one ring slot free
   always_comb begin
      state_nxt = state;
      reqs_c    = '0;
      in_rdy_c  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (eligible_c)
               state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (!slot_guard) begin
               unique case (route_q)
                  ROUTE_PREV: reqs_c[REQ_PREV] = (term.num_free_east > c_free_min);
                  ROUTE_TERM: reqs_c[REQ_TERM] = 1'b1;
                  ROUTE_NEXT: reqs_c[REQ_NEXT] = (term.num_free_west > c_free_min);
                  default:    reqs_c = '0;
               endcase
            end
            if (slot_guard) begin
               state_nxt = ST_IDLE;
            end else if (|(reqs_c & term.grants)) begin
               in_rdy_c  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!term.in_val) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign term.reqs   = reqs_c;
   assign term.in_rdy = in_rdy_c;
endmodule
